hazard_stall_ctrl: RTL and testbench

- Central pipeline sequencing controller for the filter processor.
- Drives hold (EN) and bubble/flush controls of the IF/ID, ID/EXE (Register_REG_EXE) and EXE/MEM pipeline registers.
- Detects load-use hazards, selects operand forwarding, squashes on taken branches, and freezes upstream stages during multi-cycle EXE filter operations.
- Sits beside the decode stage; consumes register indices from ID, EXE, MEM and WB.

---
 rtl/hazard_stall_ctrl_if.sv | 26 ++
 rtl/hazard_stall_ctrl.sv | 147 ++++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline-side view of the hazard/stall controller: register indices and events in,
// hold/flush/bubble/forwarding controls out.
interface hazard_stall_ctrl_if #(parameter int REG_AW = 4);
    logic [REG_AW-1:0] id_Ra, id_Rb, exe_rd, mem_rd, wb_rd;
    logic              id_useA, id_useB;
    logic              exe_wr, exe_memread, mem_wr, wb_wr;
    logic              branch_taken, mc_start, mc_done;
    logic              o_hold_pc, o_hold_ifid, o_hold_idexe;
    logic              o_flush_ifid, o_bubble_idexe, o_bubble_exemem;
    logic [1:0]        o_fwdA, o_fwdB;
    logic              o_busy, o_mc_err;

    modport master (
        output id_Ra, id_Rb, id_useA, id_useB, exe_rd, exe_wr, exe_memread,
               mem_rd, mem_wr, wb_rd, wb_wr, branch_taken, mc_start, mc_done,
        input  o_hold_pc, o_hold_ifid, o_hold_idexe, o_flush_ifid, o_bubble_idexe,
               o_bubble_exemem, o_fwdA, o_fwdB, o_busy, o_mc_err
    );

    modport slave (
        input  id_Ra, id_Rb, id_useA, id_useB, exe_rd, exe_wr, exe_memread,
               mem_rd, mem_wr, wb_rd, wb_wr, branch_taken, mc_start, mc_done,
        output o_hold_pc, o_hold_ifid, o_hold_idexe, o_flush_ifid, o_bubble_idexe,
               o_bubble_exemem, o_fwdA, o_fwdB, o_busy, o_mc_err
    );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing controller: load-use stalls, forwarding select, branch squash and
// multi-cycle EXE freeze. Optional perf counters under `HAZARD_PERF_CNT_EN.
module hazard_stall_ctrl #(
    parameter int LD_STALL_CYCLES = 1,
    parameter int MC_TIMEOUT      = 255,
    parameter int REG_AW          = 4
) (
    input logic clk,
    input logic rst,
    hazard_stall_ctrl_if.slave bus
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] o_stall_cnt,
    output logic [31:0] o_flush_cnt
`endif
);
    typedef enum logic [1:0] {RUN, LD_STALL, MC_BUSY} state_t;

    state_t      state, state_nx;
    logic [2:0]  cnt, cnt_nx;
    logic [7:0]  tmo, tmo_nx;
    logic        pend_flush, pend_flush_nx;
    logic        mc_err, mc_err_nx;
    logic        hold_pc, hold_ifid, hold_idexe, flush_ifid, bub_idexe, bub_exemem;
    logic [1:0]  fwd_a, fwd_b;
    logic [REG_AW-1:0] ra, rb, erd, mrd, wrd;
    logic        hz;

    assign ra  = bus.id_Ra;
    assign rb  = bus.id_Rb;
    assign erd = bus.exe_rd;
    assign mrd = bus.mem_rd;
    assign wrd = bus.wb_rd;

    assign hz = bus.exe_memread & bus.exe_wr &
                ((bus.id_useA & (erd == ra)) | (bus.id_useB & (erd == rb)));

    // Forwarding ignores id_use*: selecting a bypass for an unused operand is harmless.
    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (!rst) begin
            if (bus.mem_wr && mrd == ra)      fwd_a = 2'b01;
            else if (bus.wb_wr && wrd == ra)  fwd_a = 2'b10;
            if (bus.mem_wr && mrd == rb)      fwd_b = 2'b01;
            else if (bus.wb_wr && wrd == rb)  fwd_b = 2'b10;
        end
    end

    always_comb begin
        hold_pc       = 1'b0;
        hold_ifid     = 1'b0;
        hold_idexe    = 1'b0;
        flush_ifid    = 1'b0;
        bub_idexe     = 1'b0;
        bub_exemem    = 1'b0;
        state_nx      = state;
        cnt_nx        = cnt;
        tmo_nx        = tmo;
        pend_flush_nx = pend_flush;
        mc_err_nx     = mc_err;
        if (!rst) begin
            case (state)
                RUN: begin
                    if (bus.mc_start) begin
                        {hold_pc, hold_ifid, hold_idexe, bub_exemem} = 4'b1111;
                        state_nx      = MC_BUSY;
                        tmo_nx        = 8'd0;
                        pend_flush_nx = bus.branch_taken;
                    end else if (bus.branch_taken) begin
                        {flush_ifid, bub_idexe} = 2'b11;
                    end else if (hz) begin
                        {hold_pc, hold_ifid, bub_idexe} = 3'b111;
                        if (LD_STALL_CYCLES > 1) begin
                            state_nx = LD_STALL;
                            cnt_nx   = 3'(LD_STALL_CYCLES - 1);
                        end
                    end
                end
                LD_STALL: begin
                    if (bus.branch_taken) begin
                        {flush_ifid, bub_idexe} = 2'b11;
                        state_nx = RUN;
                        cnt_nx   = 3'd0;
                    end else begin
                        {hold_pc, hold_ifid, bub_idexe} = 3'b111;
                        cnt_nx = cnt - 3'd1;
                        if (cnt == 3'd1) state_nx = RUN;
                    end
                end
                MC_BUSY: begin
                    // Timeout exit happens in the MC_TIMEOUT-th busy cycle.
                    if (bus.mc_done || tmo == 8'(MC_TIMEOUT - 1)) begin
                        if (pend_flush) {flush_ifid, bub_idexe} = 2'b11;
                        if (!bus.mc_done) mc_err_nx = 1'b1;
                        pend_flush_nx = 1'b0;
                        tmo_nx        = 8'd0;
                        state_nx      = RUN;
                    end else begin
                        {hold_pc, hold_ifid, hold_idexe, bub_exemem} = 4'b1111;
                        tmo_nx = tmo + 8'd1;
                    end
                end
                default: state_nx = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RUN;
            cnt        <= 3'd0;
            tmo        <= 8'd0;
            pend_flush <= 1'b0;
            mc_err     <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            tmo        <= tmo_nx;
            pend_flush <= pend_flush_nx;
            mc_err     <= mc_err_nx;
        end
    end

    assign bus.o_hold_pc       = hold_pc;
    assign bus.o_hold_ifid     = hold_ifid;
    assign bus.o_hold_idexe    = hold_idexe;
    assign bus.o_flush_ifid    = flush_ifid;
    assign bus.o_bubble_idexe  = bub_idexe;
    assign bus.o_bubble_exemem = bub_exemem;
    assign bus.o_fwdA          = fwd_a;
    assign bus.o_fwdB          = fwd_b;
    assign bus.o_busy          = (state != RUN);
    assign bus.o_mc_err        = mc_err;

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            o_stall_cnt <= 32'd0;
            o_flush_cnt <= 32'd0;
        end else begin
            if (hold_pc && o_stall_cnt != 32'hFFFF_FFFF)    o_stall_cnt <= o_stall_cnt + 32'd1;
            if (flush_ifid && o_flush_cnt != 32'hFFFF_FFFF) o_flush_cnt <= o_flush_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench: instance A (1-cycle load stall, long timeout), instance B (3-cycle stall, timeout 4).
module tb_hazard_stall_ctrl;
    logic clk = 1'b0;
    logic rst;
    logic [3:0] id_Ra, id_Rb, exe_rd, mem_rd, wb_rd;
    logic id_useA, id_useB, exe_wr, exe_memread, mem_wr, wb_wr, branch_taken, mc_start, mc_done;

    always #5 clk = ~clk;

    hazard_stall_ctrl_if #(.REG_AW(4)) ifa ();
    hazard_stall_ctrl_if #(.REG_AW(4)) ifb ();

    assign ifa.id_Ra = id_Ra;   assign ifb.id_Ra = id_Ra;
    assign ifa.id_Rb = id_Rb;   assign ifb.id_Rb = id_Rb;
    assign ifa.exe_rd = exe_rd; assign ifb.exe_rd = exe_rd;
    assign ifa.mem_rd = mem_rd; assign ifb.mem_rd = mem_rd;
    assign ifa.wb_rd = wb_rd;   assign ifb.wb_rd = wb_rd;
    assign ifa.id_useA = id_useA; assign ifb.id_useA = id_useA;
    assign ifa.id_useB = id_useB; assign ifb.id_useB = id_useB;
    assign ifa.exe_wr = exe_wr;   assign ifb.exe_wr = exe_wr;
    assign ifa.exe_memread = exe_memread; assign ifb.exe_memread = exe_memread;
    assign ifa.mem_wr = mem_wr; assign ifb.mem_wr = mem_wr;
    assign ifa.wb_wr = wb_wr;   assign ifb.wb_wr = wb_wr;
    assign ifa.branch_taken = branch_taken; assign ifb.branch_taken = branch_taken;
    assign ifa.mc_start = mc_start; assign ifb.mc_start = mc_start;
    assign ifa.mc_done = mc_done;   assign ifb.mc_done = mc_done;

    hazard_stall_ctrl #(.LD_STALL_CYCLES(1), .MC_TIMEOUT(255), .REG_AW(4)) dut_a (
        .clk(clk), .rst(rst), .bus(ifa.slave)
`ifdef HAZARD_PERF_CNT_EN
        , .o_stall_cnt(), .o_flush_cnt()
`endif
    );
    hazard_stall_ctrl #(.LD_STALL_CYCLES(3), .MC_TIMEOUT(4), .REG_AW(4)) dut_b (
        .clk(clk), .rst(rst), .bus(ifb.slave)
`ifdef HAZARD_PERF_CNT_EN
        , .o_stall_cnt(), .o_flush_cnt()
`endif
    );

    // {hold_pc, hold_ifid, hold_idexe, flush_ifid, bubble_idexe, bubble_exemem, fwdA, fwdB, busy, mc_err}
    logic [11:0] out_a, out_b;
    assign out_a = {ifa.o_hold_pc, ifa.o_hold_ifid, ifa.o_hold_idexe, ifa.o_flush_ifid,
                    ifa.o_bubble_idexe, ifa.o_bubble_exemem, ifa.o_fwdA, ifa.o_fwdB,
                    ifa.o_busy, ifa.o_mc_err};
    assign out_b = {ifb.o_hold_pc, ifb.o_hold_ifid, ifb.o_hold_idexe, ifb.o_flush_ifid,
                    ifb.o_bubble_idexe, ifb.o_bubble_exemem, ifb.o_fwdA, ifb.o_fwdB,
                    ifb.o_busy, ifb.o_mc_err};

    localparam logic [5:0] C_NONE = 6'b000000;
    localparam logic [5:0] C_HZ   = 6'b110010;
    localparam logic [5:0] C_BR   = 6'b000110;
    localparam logic [5:0] C_MC   = 6'b111001;

    typedef struct {
        string       tag;
        bit          sel_b;
        logic [11:0] exp;
    } sb_t;
    sb_t sb_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    function automatic logic [11:0] ex(input logic [5:0] ctl, input logic [1:0] fa, fb,
                                       input logic busy, err);
        return {ctl, fa, fb, busy, err};
    endfunction

    task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // One cycle: expectation queued with the stimulus, popped and compared mid-cycle.
    task automatic cyc(input bit sel_b, input logic [11:0] exp, input string tag);
        sb_t e;
        sb_q.push_back('{tag, sel_b, exp});
        @(negedge clk);
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 12'hFFF, 12'h000);
        end else begin
            e = sb_q.pop_front();
            chk(e.tag, e.sel_b ? out_b : out_a, e.exp);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        {id_Ra, id_Rb, exe_rd, mem_rd, wb_rd} = '0;
        {id_useA, id_useB, exe_wr, exe_memread, mem_wr, wb_wr} = '0;
        {branch_taken, mc_start, mc_done} = '0;
    endtask

    task automatic set_hz();
        exe_memread = 1'b1; exe_wr = 1'b1; exe_rd = 4'd3; id_Ra = 4'd3; id_useA = 1'b1; id_Rb = 4'd7;
    endtask

    initial begin
        clr();
        rst = 1'b1;
        @(posedge clk); #1;
        // Inputs that would otherwise stall and forward: everything must read 0 in reset.
        set_hz(); mem_rd = 4'd3; mem_wr = 1'b1;
        cyc(0, ex(C_NONE, 2'b00, 2'b00, 0, 0), "rst_out");
        rst = 1'b0; clr();
        cyc(0, ex(C_NONE, 2'b00, 2'b00, 0, 0), "idle");

        set_hz();
        cyc(0, ex(C_HZ, 2'b00, 2'b00, 0, 0), "ld_use");
        exe_memread = 1'b0; exe_wr = 1'b0; mem_rd = 4'd3; mem_wr = 1'b1;
        cyc(0, ex(C_NONE, 2'b01, 2'b00, 0, 0), "ld_fwd");
        set_hz(); mem_wr = 1'b0; id_useA = 1'b0;
        cyc(0, ex(C_NONE, 2'b00, 2'b00, 0, 0), "no_use");
        id_Rb = 4'd3; id_useB = 1'b1;
        cyc(0, ex(C_HZ, 2'b00, 2'b00, 0, 0), "hz_b");
        exe_wr = 1'b0;
        cyc(0, ex(C_NONE, 2'b00, 2'b00, 0, 0), "hz_nowr");

        clr(); mem_rd = 4'd5; wb_rd = 4'd5; mem_wr = 1'b1; wb_wr = 1'b1; id_Rb = 4'd5; id_Ra = 4'd1;
        cyc(0, ex(C_NONE, 2'b00, 2'b01, 0, 0), "fwd_pri");
        mem_wr = 1'b0;
        cyc(0, ex(C_NONE, 2'b00, 2'b10, 0, 0), "fwd_wb");
        id_useB = 1'b1;
        cyc(0, ex(C_NONE, 2'b00, 2'b10, 0, 0), "fwd_useb");
        wb_wr = 1'b0;
        cyc(0, ex(C_NONE, 2'b00, 2'b00, 0, 0), "fwd_none");
        clr(); mem_wr = 1'b1;
        cyc(0, ex(C_NONE, 2'b01, 2'b01, 0, 0), "fwd_r0");

        clr(); set_hz(); branch_taken = 1'b1;
        cyc(0, ex(C_BR, 2'b00, 2'b00, 0, 0), "br_hz");
        clr();
        cyc(0, ex(C_NONE, 2'b00, 2'b00, 0, 0), "br_after");

        mc_start = 1'b1;
        cyc(0, ex(C_MC, 2'b00, 2'b00, 0, 0), "mc_start");
        for (int i = 1; i <= 5; i++) begin
            mc_start = (i == 3);
            cyc(0, ex(C_MC, 2'b00, 2'b00, 1, 0), "mc_busy");
        end
        mc_start = 1'b0; mc_done = 1'b1;
        cyc(0, ex(C_NONE, 2'b00, 2'b00, 1, 0), "mc_done");
        mc_done = 1'b0;
        cyc(0, ex(C_NONE, 2'b00, 2'b00, 0, 0), "mc_run");

        mc_start = 1'b1; branch_taken = 1'b1;
        cyc(0, ex(C_MC, 2'b00, 2'b00, 0, 0), "mcbr_start");
        clr();
        cyc(0, ex(C_MC, 2'b00, 2'b00, 1, 0), "mcbr_busy");
        cyc(0, ex(C_MC, 2'b00, 2'b00, 1, 0), "mcbr_busy");
        mc_done = 1'b1;
        cyc(0, ex(C_BR, 2'b00, 2'b00, 1, 0), "mcbr_flush");
        clr();
        cyc(0, ex(C_NONE, 2'b00, 2'b00, 0, 0), "mcbr_run");
        mc_start = 1'b1;
        cyc(0, ex(C_MC, 2'b00, 2'b00, 0, 0), "mc2_start");
        clr(); mc_done = 1'b1;
        cyc(0, ex(C_NONE, 2'b00, 2'b00, 1, 0), "mc_nopf");
        clr();

        mc_start = 1'b1;
        cyc(0, ex(C_MC, 2'b00, 2'b00, 0, 0), "mcr_start");
        clr();
        cyc(0, ex(C_MC, 2'b00, 2'b00, 1, 0), "mcr_busy");
        rst = 1'b1;
        cyc(0, ex(C_NONE, 2'b00, 2'b00, 1, 0), "rst_mid");
        rst = 1'b0;
        cyc(0, ex(C_NONE, 2'b00, 2'b00, 0, 0), "rst_after");

        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;

        set_hz();
        cyc(1, ex(C_HZ, 2'b00, 2'b00, 0, 0), "ld3_0");
        clr();
        cyc(1, ex(C_HZ, 2'b00, 2'b00, 1, 0), "ld3_1");
        cyc(1, ex(C_HZ, 2'b00, 2'b00, 1, 0), "ld3_2");
        cyc(1, ex(C_NONE, 2'b00, 2'b00, 0, 0), "ld3_end");
        set_hz();
        cyc(1, ex(C_HZ, 2'b00, 2'b00, 0, 0), "ld3a_0");
        clr(); branch_taken = 1'b1;
        cyc(1, ex(C_BR, 2'b00, 2'b00, 1, 0), "ld3_abort");
        clr();
        cyc(1, ex(C_NONE, 2'b00, 2'b00, 0, 0), "ld3a_run");

        mc_start = 1'b1;
        cyc(1, ex(C_MC, 2'b00, 2'b00, 0, 0), "to_start");
        clr();
        for (int i = 0; i < 3; i++) cyc(1, ex(C_MC, 2'b00, 2'b00, 1, 0), "to_busy");
        cyc(1, ex(C_NONE, 2'b00, 2'b00, 1, 0), "to_exit");
        for (int i = 0; i < 3; i++) cyc(1, ex(C_NONE, 2'b00, 2'b00, 0, 1), "to_err");
        mc_start = 1'b1;
        cyc(1, ex(C_MC, 2'b00, 2'b00, 0, 1), "err_start");
        clr(); mc_done = 1'b1;
        cyc(1, ex(C_NONE, 2'b00, 2'b00, 1, 1), "err_done");
        clr();
        cyc(1, ex(C_NONE, 2'b00, 2'b00, 0, 1), "err_sticky");
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        cyc(1, ex(C_NONE, 2'b00, 2'b00, 0, 0), "err_clr");

        if (sb_q.size() != 0) chk("sb_leftover", 12'(sb_q.size()), 12'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
